mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one combinational IN_WIDTH x IN_WIDTH multiplier instance among NUM_REQ requesters.
- Each requester presents operands through a valid/ready request channel and receives its product on a valid/ready response channel.
- The block arbitrates round-robin, registers the operands that drive the shared multiplier, registers the product, and holds it until the granted requester accepts it.
- It sits between the requesting datapath blocks and the single multiplier instance.

Parameters:
- IN_WIDTH, 4, operand width of the shared multiplier.
- OUT_WIDTH, IN_WIDTH+IN_WIDTH, product width; must equal 2*IN_WIDTH.
- NUM_REQ, 4, number of requesters (2..8).
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*IN_WIDTH  packed operand A; requester i uses bits [i*IN_WIDTH +: IN_WIDTH].
- req_b  input  NUM_REQ*IN_WIDTH  packed operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot request accept.
- rsp_valid  output  NUM_REQ  one-hot response valid, for the granted requester.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_data  output  OUT_WIDTH  registered product, shared by all requesters.
- mult_a  output  IN_WIDTH  registered operand A to the multiplier's a port.
- mult_b  output  IN_WIDTH  registered operand B to the multiplier's b port.
- mult_out  input  OUT_WIDTH  product from the multiplier's out port.
- busy  output  1  high whenever state is not IDLE.
- op_count  output  CNT_WIDTH  count of completed responses; wraps.

Behaviour:
- Reset values while rst_n=0:
  - state=IDLE; mult_a=0, mult_b=0, rsp_data=0.
  - rsp_valid=0, req_ready=0, busy=0, op_count=0.
  - grant=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- State machine: IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the winner w is the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[w]=1 combinationally in this cycle only; all other req_ready bits are 0.
  - On the clock edge: mult_a <= req_a slice w, mult_b <= req_b slice w, grant <= w, state <= CALC.
  - With no req_valid set, state stays IDLE and req_ready=0.
- CALC (exactly one cycle):
  - rsp_data <= mult_out (full OUT_WIDTH, unsigned, no truncation).
  - state <= RESP.
  - mult_a and mult_b are held stable throughout CALC.
- RESP:
  - rsp_valid[grant]=1 (registered, one-hot); rsp_data is held stable.
  - When rsp_ready[grant]=1: rsp_valid clears on the next edge, last_grant <= grant, op_count <= op_count+1 (wraps from 2^CNT_WIDTH-1 to 0), state <= IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency:
  - Request accept to rsp_valid: 2 cycles.
  - Minimum issue interval: 3 cycles per operation, because IDLE is always revisited.
- Handshake rules:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Deasserting req_valid before the grant is permitted; the request is simply not considered.
  - rsp_ready asserted before rsp_valid is allowed and completes the response in the first RESP cycle.
  - req_ready is never asserted outside IDLE; new requests wait while busy.
- Fairness: a requester that holds req_valid is granted within NUM_REQ operations.
- Simultaneous events:
  - Several req_valid bits in the same IDLE cycle: only the round-robin winner is accepted.
  - A requester whose response completes and that still holds req_valid has the lowest priority in the following IDLE cycle.
- Reset mid-operation:
  - Asynchronous assertion of rst_n aborts the operation immediately; no response is ever issued for it.
  - All state returns to the reset values.
- mult_a and mult_b change only on IDLE->CALC transitions, which limits toggling on the multiplier.

Test Plan:
- Reset, then req_valid=4'b0001, a0=3, b0=5, rsp_ready=1 -> req_ready=0001 in the request cycle; rsp_valid=0001 and rsp_data=15 two cycles later; op_count=1 afterwards.
- req_valid=4'b1111 held, all operand pairs distinct, rsp_ready=1111 -> grant order 0,1,2,3,0; one response every 3 cycles; each rsp_data equals that requester's product.
- Requester 2 with a=15, b=15 and rsp_ready low for 5 cycles -> rsp_valid[2] and rsp_data=225 held steady; no req_ready while waiting; completion on the cycle rsp_ready[2] rises.
- rst_n pulsed low during CALC for requester 1 -> all outputs return to reset values at once; no rsp_valid for requester 1; the next request from requester 1 completes normally.
- a=0, b=9, then a=15, b=1 -> rsp_data=0, then rsp_data=15.
- CNT_WIDTH=4, 17 completed operations -> op_count reads 1.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Shares one external combinational multiplier among NUM_REQ requesters.
// Requests are picked round-robin in IDLE, the winner's operands are
// registered onto mult_a/mult_b, the product is captured one cycle later
// and held on rsp_data until the granted requester takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_a/b    packed operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   req_ready  one-hot request accept (IDLE only)
//   rsp_valid  one-hot response valid for the granted requester
//   rsp_ready  per-requester response accept (only the granted bit matters)
//   rsp_data   registered product, shared by all requesters
//   mult_a/b   registered operands to the multiplier
//   mult_out   product returned by the multiplier
//   busy       high whenever the FSM is not in IDLE
//   op_count   completed responses, wraps
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pick round-robin winner, load its operands onto the multiplier
// CALC  | multiplier settles; capture its product into rsp_data
// RESP  | rsp_valid held for the granted requester until it accepts

module mult_share_arbiter #(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = IN_WIDTH + IN_WIDTH,
   parameter int NUM_REQ   = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  req_a,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  req_b,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [OUT_WIDTH-1:0]         rsp_data,
   output logic [IN_WIDTH-1:0]          mult_a,
   output logic [IN_WIDTH-1:0]          mult_b,
   input  logic [OUT_WIDTH-1:0]         mult_out,
   output logic                         busy,
   output logic [CNT_WIDTH-1:0]         op_count
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [GW-1:0]          r_grant;
   logic [GW-1:0]          r_last_grant;
   logic [IN_WIDTH-1:0]    r_mult_a;
   logic [IN_WIDTH-1:0]    r_mult_b;
   logic [OUT_WIDTH-1:0]   r_rsp_data;
   logic [NUM_REQ-1:0]     r_rsp_valid;
   logic [CNT_WIDTH-1:0]   r_op_count;

   logic                   w_found;
   logic [GW-1:0]          w_winner;
   logic [GW-1:0]          w_scan_idx;
   logic [NUM_REQ-1:0]     w_req_ready;
   logic                   w_load;
   logic                   w_capture;
   logic                   w_done;
   logic [NUM_REQ-1:0]     w_grant_onehot;

   // Round-robin scan: start just after the last completed grant so the
   // requester that was just served ends up with the lowest priority.
   always_comb begin
      w_found    = 1'b0;
      w_winner   = '0;
      w_scan_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_scan_idx = GW'((int'(r_last_grant) + k) % NUM_REQ);
         if (!w_found && req_valid[w_scan_idx]) begin
            w_found  = 1'b1;
            w_winner = w_scan_idx;
         end
      end
   end

   assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // rst_n gate keeps req_ready low while reset is held.
            if (w_found && rst_n) begin
               w_req_ready[w_winner] = 1'b1;
               w_load                = 1'b1;
               w_state_nxt           = S_CALC;
            end
         end
         S_CALC: begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready[r_grant]) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Operands only move on IDLE->CALC, so the multiplier inputs stay quiet
   // for the rest of the operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mult_a     <= '0;
         r_mult_b     <= '0;
         r_grant      <= '0;
         r_last_grant <= LAST_IDX;
         r_rsp_data   <= '0;
         r_rsp_valid  <= '0;
         r_op_count   <= '0;
      end else begin
         if (w_load) begin
            r_mult_a <= req_a[w_winner*IN_WIDTH +: IN_WIDTH];
            r_mult_b <= req_b[w_winner*IN_WIDTH +: IN_WIDTH];
            r_grant  <= w_winner;
         end
         if (w_capture) begin
            r_rsp_data  <= mult_out;
            r_rsp_valid <= w_grant_onehot;
         end
         if (w_done) begin
            r_rsp_valid  <= '0;
            r_last_grant <= r_grant;
            r_op_count   <= r_op_count + CNT_WIDTH'(1);
         end
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign mult_a    = r_mult_a;
   assign mult_b    = r_mult_b;
   assign busy      = (r_state != S_IDLE);
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

   localparam int IW = 4;
   localparam int OW = 8;
   localparam int NR = 4;
   localparam int CW = 4;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*IW-1:0]  req_a;
   logic [NR*IW-1:0]  req_b;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [OW-1:0]     rsp_data;
   logic [IW-1:0]     mult_a;
   logic [IW-1:0]     mult_b;
   logic [OW-1:0]     mult_out;
   logic              busy;
   logic [CW-1:0]     op_count;

   int total = 0;
   int bad   = 0;

   mult_share_arbiter #(
      .IN_WIDTH (IW),
      .OUT_WIDTH(OW),
      .NUM_REQ  (NR),
      .CNT_WIDTH(CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .mult_a   (mult_a),
      .mult_b   (mult_b),
      .mult_out (mult_out),
      .busy     (busy),
      .op_count (op_count)
   );

   // The shared multiplier itself.
   assign mult_out = OW'(mult_a) * OW'(mult_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation for a single requester, starting in IDLE at edge+1.
   task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] p, input string tag);
      logic [NR-1:0] oh;
      oh = 4'b0001 << r;
      req_a[r*IW +: IW] = a;
      req_b[r*IW +: IW] = b;
      req_valid = oh;
      rsp_ready = 4'b1111;
      #1;
      chk({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
      tick();
      req_valid = '0;
      tick();
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(p));
      tick();
   endtask

   int            exp_g [5] = '{0, 1, 2, 3, 0};
   logic [7:0]    exp_p [5] = '{8'd6, 8'd20, 8'd42, 8'd72, 8'd6};
   logic [3:0]    exp_a [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd2};

   initial begin
      logic [3:0] ta, tb;
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '0;

      // reset values
      #3;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_mult_a", 32'(mult_a), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_op_count", 32'(op_count), 0);
      tick();
      rst_n = 1'b1;

      // single request 3*5
      req_valid = 4'b0001;
      req_a[3:0] = 4'd3;
      req_b[3:0] = 4'd5;
      rsp_ready = 4'b0001;
      #1;
      chk("t1_req_ready", 32'(req_ready), 32'h1);
      chk("t1_busy_idle", 32'(busy), 0);
      tick();
      req_valid = '0;
      chk("t1_mult_a", 32'(mult_a), 3);
      chk("t1_mult_b", 32'(mult_b), 5);
      chk("t1_busy_calc", 32'(busy), 1);
      chk("t1_rsp_valid_calc", 32'(rsp_valid), 0);
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_data", 32'(rsp_data), 15);
      tick();
      chk("t1_rsp_valid_done", 32'(rsp_valid), 0);
      chk("t1_op_count", 32'(op_count), 1);
      chk("t1_busy_done", 32'(busy), 0);

      // all four requesting: round-robin from requester 0 after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_a = {4'd8, 4'd6, 4'd4, 4'd2};
      req_b = {4'd9, 4'd7, 4'd5, 4'd3};
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk($sformatf("t2_req_ready_%0d", j), 32'(req_ready), 32'(1 << exp_g[j]));
         tick();
         chk($sformatf("t2_calc_ready_%0d", j), 32'(req_ready), 0);
         chk($sformatf("t2_mult_a_%0d", j), 32'(mult_a), 32'(exp_a[j]));
         tick();
         chk($sformatf("t2_rsp_valid_%0d", j), 32'(rsp_valid), 32'(1 << exp_g[j]));
         chk($sformatf("t2_rsp_data_%0d", j), 32'(rsp_data), 32'(exp_p[j]));
         tick();
      end
      req_valid = '0;
      chk("t2_op_count", 32'(op_count), 5);

      // requester 2, 15*15, response stalled for 5 cycles
      req_a[11:8] = 4'd15;
      req_b[11:8] = 4'd15;
      req_valid = 4'b0100;
      rsp_ready = 4'b0000;
      #1;
      chk("t3_req_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b1011;
      rsp_ready = 4'b1011;
      #1;
      chk("t3_calc_ready", 32'(req_ready), 0);
      tick();
      for (int j = 0; j < 5; j++) begin
         #1;
         chk($sformatf("t3_hold_valid_%0d", j), 32'(rsp_valid), 32'h4);
         chk($sformatf("t3_hold_data_%0d", j), 32'(rsp_data), 225);
         chk($sformatf("t3_hold_ready_%0d", j), 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 4'b1111;
      #1;
      chk("t3_last_valid", 32'(rsp_valid), 32'h4);
      tick();
      chk("t3_done_valid", 32'(rsp_valid), 0);
      chk("t3_op_count", 32'(op_count), 6);
      chk("t3_next_winner", 32'(req_ready), 32'h8);
      tick();
      req_valid = '0;
      tick();
      chk("t3_r3_valid", 32'(rsp_valid), 32'h8);
      chk("t3_r3_data", 32'(rsp_data), 72);
      tick();
      chk("t3_r3_count", 32'(op_count), 7);

      // reset asserted during CALC for requester 1
      req_valid = 4'b0010;
      #1;
      chk("t4_req_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      #1;
      chk("t4_mult_a_calc", 32'(mult_a), 4);
      #1;
      rst_n = 1'b0;
      req_valid = 4'b0010;
      #1;
      chk("t4_busy", 32'(busy), 0);
      chk("t4_rsp_valid", 32'(rsp_valid), 0);
      chk("t4_mult_a", 32'(mult_a), 0);
      chk("t4_mult_b", 32'(mult_b), 0);
      chk("t4_rsp_data", 32'(rsp_data), 0);
      chk("t4_op_count", 32'(op_count), 0);
      chk("t4_req_ready", 32'(req_ready), 0);
      tick();
      chk("t4_rsp_valid_edge", 32'(rsp_valid), 0);
      rst_n = 1'b1;
      req_valid = '0;
      run_op(1, 4'd4, 4'd5, 8'd20, "t4_retry");
      chk("t4_retry_count", 32'(op_count), 1);

      // zero operand and unit operand
      run_op(0, 4'd0, 4'd9, 8'd0, "t5_zero");
      run_op(0, 4'd15, 4'd1, 8'd15, "t5_one");
      chk("t5_op_count", 32'(op_count), 3);

      // op_count wrap with 4-bit counter
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         ta = 4'(i);
         tb = 4'((i * 3) % 16);
         run_op(i % 4, ta, tb, 8'(ta) * 8'(tb), $sformatf("t6_op%0d", i));
         if (i == 14) chk("t6_count_15", 32'(op_count), 15);
         if (i == 15) chk("t6_count_wrap", 32'(op_count), 0);
      end
      chk("t6_count_17", 32'(op_count), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
